// File: rtl/fp_mul_normalizer.sv
// fp_mul_normalizer: takes the raw 2N-bit mantissa product, the biased
// exponent sum and the sign from the sequential mantissa multiplier. It
// normalizes, rounds to nearest-even, saturates or flushes on exponent
// overflow/underflow, and packs an IEEE-754 single-precision result.
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. Input side: in_ready is decoded from state (IDLE) and rst only.
// Output side: result and flags are held stable while out_valid=1 until
// out_ready=1.
module fp_mul_normalizer #(
   parameter int N    = 24,
   parameter int E    = 8,
   parameter int BIAS = 127
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2*N-1:0]   prod,
   input  logic [E+1:0]     exp_sum,
   input  logic             sign,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [E+N-1:0]   result,
   output logic             overflow,
   output logic             underflow,
   output logic             inexact,
   output logic [1:0]       o_dbg_state
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_NORM  = 2'd1,
      S_ROUND = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   // Internal exponent is signed E+3 bits: wide enough for -BIAS..2^(E+1)+1.
   localparam logic signed [E+2:0] L_BIAS = (E+3)'(BIAS);
   localparam logic signed [E+2:0] L_ONE  = (E+3)'(1);
   localparam logic signed [E+2:0] L_ZERO = '0;
   localparam logic signed [E+2:0] L_EMAX = (E+3)'((1 << E) - 1);

   state_t                r_state;

   // Captured operands
   logic [2*N-1:0]        r_prod;
   logic [E+1:0]          r_exp_sum;
   logic                  r_sign;
   logic                  r_zero;

   // Normalized values handed from NORM to ROUND
   logic [N-1:0]          r_mant;
   logic                  r_guard;
   logic                  r_sticky;
   logic signed [E+2:0]   r_exp;

   // Registered outputs
   logic                  r_out_valid;
   logic [E+N-1:0]        r_result;
   logic                  r_overflow;
   logic                  r_underflow;
   logic                  r_inexact;

   // NORM stage combinational results
   logic signed [E+2:0]   w_exp_base;
   logic signed [E+2:0]   w_norm_exp;
   logic [N-1:0]          w_norm_mant;
   logic                  w_norm_guard;
   logic                  w_norm_sticky;

   // ROUND stage combinational results
   logic                  w_round_up;
   logic                  w_carry;
   logic [N-2:0]          w_rfrac;
   logic signed [E+2:0]   w_rexp;
   logic [E+N-1:0]        w_res;
   logic                  w_ovf;
   logic                  w_unf;
   logic                  w_inx;

   assign in_ready    = rst && (r_state == S_IDLE);
   assign out_valid   = r_out_valid;
   assign result      = r_result;
   assign overflow    = r_overflow;
   assign underflow   = r_underflow;
   assign inexact     = r_inexact;
   assign o_dbg_state = r_state;

   assign w_exp_base = $signed({1'b0, r_exp_sum}) - L_BIAS;

   // Select the normalization window depending on whether the product is in [2,4)
   always_comb begin
      w_norm_exp    = w_exp_base;
      w_norm_mant   = r_prod[2*N-2:N-1];
      w_norm_guard  = r_prod[N-2];
      w_norm_sticky = |r_prod[N-3:0];
      if (r_prod[2*N-1]) begin
         w_norm_exp    = w_exp_base + L_ONE;
         w_norm_mant   = r_prod[2*N-1:N];
         w_norm_guard  = r_prod[N-1];
         w_norm_sticky = |r_prod[N-2:0];
      end
   end

   // Round to nearest-even; an all-ones mantissa that rounds up renormalizes to 1.0
   assign w_round_up = r_guard & (r_sticky | r_mant[0]);
   assign w_carry    = w_round_up & (&r_mant);
   assign w_rfrac    = w_carry ? '0 : (r_mant[N-2:0] + (N-1)'(w_round_up));
   assign w_rexp     = r_exp + (w_carry ? L_ONE : L_ZERO);

   // Classify the rounded value: zero, overflow, underflow, then normal
   always_comb begin
      w_res = {r_sign, w_rexp[E-1:0], w_rfrac};
      w_ovf = 1'b0;
      w_unf = 1'b0;
      w_inx = r_guard | r_sticky;
      if (r_zero) begin
         w_res = {r_sign, {(E+N-1){1'b0}}};
         w_inx = 1'b0;
      end else if (w_rexp >= L_EMAX) begin
         w_res = {r_sign, {E{1'b1}}, {(N-1){1'b0}}};
         w_ovf = 1'b1;
         w_inx = 1'b1;
      end else if (w_rexp <= L_ZERO) begin
         w_res = {r_sign, {(E+N-1){1'b0}}};
         w_unf = 1'b1;
         w_inx = 1'b1;
      end
   end

   // Control FSM with all datapath and output registers
   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state     <= S_IDLE;
         r_prod      <= '0;
         r_exp_sum   <= '0;
         r_sign      <= 1'b0;
         r_zero      <= 1'b0;
         r_mant      <= '0;
         r_guard     <= 1'b0;
         r_sticky    <= 1'b0;
         r_exp       <= '0;
         r_out_valid <= 1'b0;
         r_result    <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
         r_inexact   <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_prod    <= prod;
                  r_exp_sum <= exp_sum;
                  r_sign    <= sign;
                  r_zero    <= (prod == '0);
                  r_state   <= S_NORM;
               end
            end
            S_NORM: begin
               r_mant   <= w_norm_mant;
               r_guard  <= w_norm_guard;
               r_sticky <= w_norm_sticky;
               r_exp    <= w_norm_exp;
               r_state  <= S_ROUND;
            end
            S_ROUND: begin
               r_result    <= w_res;
               r_overflow  <= w_ovf;
               r_underflow <= w_unf;
               r_inexact   <= w_inx;
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_state     <= S_IDLE;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fp_mul_normalizer.sv
// Testbench for fp_mul_normalizer: directed vectors with hand-computed
// results, an expected queue filled at acceptance and a monitor that pops
// on every output transfer.
module tb_fp_mul_normalizer;

   localparam int N = 24;
   localparam int E = 8;
   localparam int W = E + N + 3;   // {result, overflow, underflow, inexact}

   logic             clk;
   logic             rst;
   logic             in_valid;
   logic             in_ready;
   logic [2*N-1:0]   prod;
   logic [E+1:0]     exp_sum;
   logic             sign;
   logic             out_valid;
   logic             out_ready;
   logic [E+N-1:0]   result;
   logic             overflow;
   logic             underflow;
   logic             inexact;
   logic [1:0]       dbg_state;

   logic [W-1:0]     exp_q[$];
   int               total = 0;
   int               bad   = 0;

   fp_mul_normalizer #(.N(N), .E(E), .BIAS(127)) dut (
      .clk         (clk),
      .rst         (rst),
      .in_valid    (in_valid),
      .in_ready    (in_ready),
      .prod        (prod),
      .exp_sum     (exp_sum),
      .sign        (sign),
      .out_valid   (out_valid),
      .out_ready   (out_ready),
      .result      (result),
      .overflow    (overflow),
      .underflow   (underflow),
      .inexact     (inexact),
      .o_dbg_state (dbg_state)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   // ---------------- checking helpers ----------------
   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // ---------------- driver tasks ----------------
   task automatic wait_in_ready();
      int n;
      n = 0;
      while (!in_ready && n < 30) begin
         tick();
         n++;
      end
      if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'd1);
   endtask

   // Present one product; returns 1 time unit after the accepting edge.
   task automatic send(input logic [2*N-1:0] p, input logic [E+1:0] es, input logic sg,
                       input logic [W-1:0] expv, input bit push);
      wait_in_ready();
      prod     = p;
      exp_sum  = es;
      sign     = sg;
      in_valid = 1'b1;
      @(posedge clk);
      if (push) exp_q.push_back(expv);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic run_vec(input logic [2*N-1:0] p, input logic [E+1:0] es, input logic sg,
                          input logic [W-1:0] expv);
      send(p, es, sg, expv, 1'b1);
      wait_in_ready();
   endtask

   // ---------------- scoreboard monitor ----------------
   // A transfer happens at the next rising edge when both are high at the falling edge.
   always @(negedge clk) begin
      if (rst && out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("unexpected_output", 64'({result, overflow, underflow, inexact}), 64'd0);
         end else begin
            logic [W-1:0] e;
            e = exp_q.pop_front();
            check("result_flags", 64'({result, overflow, underflow, inexact}), 64'(e));
         end
      end
   end

   // ---------------- stimulus ----------------
   initial begin
      logic seen;
      rst       = 1'b0;
      in_valid  = 1'b0;
      prod      = '0;
      exp_sum   = '0;
      sign      = 1'b0;
      out_ready = 1'b1;

      // Reset state
      repeat (3) tick();
      check("rst_out_valid", 64'(out_valid), 64'd0);
      check("rst_result", 64'(result), 64'd0);
      check("rst_flags", 64'({overflow, underflow, inexact}), 64'd0);
      check("rst_in_ready_low", 64'(in_ready), 64'd0);
      rst = 1'b1;
      #1;
      check("in_ready_after_rst", 64'(in_ready), 64'd1);
      tick();

      // 1.5 x 1.5 with latency check: out_valid at T2, not at T1
      send(48'h900000000000, 10'd254, 1'b0, {32'h40100000, 3'b000}, 1'b1);
      tick();
      check("latency_t1_low", 64'(out_valid), 64'd0);
      tick();
      check("latency_t2_high", 64'(out_valid), 64'd1);
      wait_in_ready();

      // RNE tie to even, then round up
      run_vec(48'h400000400000, 10'd254, 1'b0, {32'h3F800000, 3'b001});
      run_vec(48'h400000C00000, 10'd254, 1'b0, {32'h3F800002, 3'b001});
      // Rounding carries out of the mantissa
      run_vec(48'h7FFFFFC00000, 10'd254, 1'b0, {32'h40000000, 3'b001});
      // Overflow, underflow, signed zero
      run_vec(48'h400000000000, 10'd400, 1'b1, {32'hFF800000, 3'b101});
      run_vec(48'h400000000000, 10'd100, 1'b0, {32'h00000000, 3'b011});
      run_vec(48'h000000000000, 10'd254, 1'b1, {32'h80000000, 3'b000});
      // Exponent edges: 254 stays normal, 255 saturates
      run_vec(48'h400000000000, 10'd381, 1'b0, {32'h7F000000, 3'b000});
      run_vec(48'h800000000000, 10'd381, 1'b0, {32'h7F800000, 3'b101});
      // Exponent 1 stays normal, exponent 0 flushes
      run_vec(48'h400000000000, 10'd128, 1'b1, {32'h80800000, 3'b000});
      run_vec(48'h400000000000, 10'd127, 1'b0, {32'h00000000, 3'b011});

      // Backpressure: result held, no second capture
      out_ready = 1'b0;
      send(48'h900000000000, 10'd254, 1'b0, {32'h40100000, 3'b000}, 1'b1);
      for (int i = 0; i < 10 && !out_valid; i++) tick();
      check("bp_out_valid", 64'(out_valid), 64'd1);
      prod     = 48'h400000000000;
      exp_sum  = 10'd254;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         check("bp_result_held", 64'({result, overflow, underflow, inexact}), 64'({32'h40100000, 3'b000}));
         check("bp_in_ready_low", 64'(in_ready), 64'd0);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_out_valid_cleared", 64'(out_valid), 64'd0);
      check("bp_in_ready_back", 64'(in_ready), 64'd1);
      repeat (4) tick();
      check("bp_no_second_output", 64'(out_valid), 64'd0);

      // Reset during NORM discards the operation
      send(48'h900000000000, 10'd254, 1'b0, '0, 1'b0);
      rst = 1'b0;
      repeat (2) tick();
      rst = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen = seen | out_valid;
      end
      check("midrst_no_output", 64'(seen), 64'd0);
      run_vec(48'h400000000000, 10'd254, 1'b0, {32'h3F800000, 3'b000});

      repeat (3) tick();
      check("queue_drained", 64'(exp_q.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/fp_mul_normalizer.md
# fp_mul_normalizer

Downstream stage of the unsigned sequential mantissa multiplier in the float32 multiply path. Consumes the raw 2N-bit mantissa product with the sign and biased-exponent sum. Normalizes, rounds to nearest-even, handles overflow and underflow, and packs an IEEE-754 single-precision result. Uses a valid/ready handshake and holds its result until the consumer accepts it.

## Interface
- N, 24, mantissa width including the hidden bit.
- E, 8, exponent field width.
- BIAS, 127, exponent bias.
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, synchronous, active-low (asserted when 0).
- in_valid  input  1  upstream has a product ready.
- in_ready  output  1  block can accept; high only in IDLE and when rst=1.
- prod  input  2N  unsigned mantissa product, value in [1,4) in 2.(2N-2) fixed point, or 0.
- exp_sum  input  E+2  unsigned sum of the two raw biased exponent fields (0..2^(E+1)-2).
- sign  input  1  result sign, the XOR of the operand signs.
- out_valid  output  1  result is valid.
- out_ready  input  1  consumer accepts the result.
- result  output  1+E+N-1  packed {sign, exponent, fraction}.
- overflow  output  1  result saturated to infinity.
- underflow  output  1  result flushed to zero.
- inexact  output  1  precision lost (guard|sticky), or overflow, or underflow.

## Operation
- FSM states: IDLE, NORM, ROUND, DONE.
- IDLE:
  - in_ready=1.
  - When in_valid=1, capture prod/exp_sum/sign and go to NORM.
- NORM (1 cycle): compute the internal exponent as a signed E+3-bit value.
  - If prod[2N-1]=1: exp = exp_sum - BIAS + 1; mant = prod[2N-1:N]; guard = prod[N-1]; sticky = |prod[N-2:0].
  - Else: exp = exp_sum - BIAS; mant = prod[2N-2:N-1]; guard = prod[N-2]; sticky = |prod[N-3:0].
  - Register mant, guard, sticky and exp. Go to ROUND.
- ROUND (1 cycle):
  - Apply RNE: increment mant when guard & (sticky | mant[0]).
  - If the increment carries out of N bits, set mant = 1<<(N-1) and exp = exp + 1.
  - Then classify, in priority order:
    - prod==0 (captured): result = {sign, 0, 0}; all flags 0.
    - exp >= 2^E-1: result = {sign, all ones, 0}; overflow=1, inexact=1.
    - exp <= 0: result = {sign, 0, 0}; underflow=1, inexact=1. Denormals are not produced.
    - Otherwise: result = {sign, exp[E-1:0], mant[N-2:0]}; inexact = guard|sticky.
  - Register result and flags, assert out_valid, go to DONE.
- DONE:
  - Hold result, flags and out_valid stable.
  - When out_ready=1, clear out_valid and go to IDLE.
  - in_ready=0; in_valid is ignored.
- Reset (rst=0 at an edge, from any state):
  - State goes to IDLE; result=0, overflow=0, underflow=0, inexact=0, out_valid=0.
  - Any in-flight operation is discarded with no output.
  - in_ready=0 while rst=0.

## Timing
- Input accepted at edge T0.
- Registers load at T1 (NORM) and T2 (ROUND); out_valid=1 from T2.
- Minimum latency: 2 cycles from acceptance to out_valid.
- Output transfer at the first edge where out_valid=1 and out_ready=1. out_valid=0 and in_ready=1 in the following cycle.
- Peak throughput is one result per 4 cycles when out_ready is held high. This is sufficient because the upstream multiplier needs N cycles per product.
- out_ready already high when out_valid rises: transfer at the next edge (T3).
- Outputs change only on clock edges. in_ready is decoded from state only, with no combinational path from in_valid or out_ready.

## Test plan
- Reset, then 1.5×1.5: prod=0x900000000000, exp_sum=254, sign=0 -> result=0x40100000, flags 0, out_valid exactly 2 cycles after acceptance.
- RNE tie and round-up: prod=0x400000400000, exp_sum=254 -> 0x3F800000, inexact=1. prod=0x400000C00000 -> 0x3F800002, inexact=1.
- Rounding carry-out: prod=0x7FFFFFC00000, exp_sum=254 -> 0x40000000, inexact=1.
- Exponent limits:
  - prod=0x400000000000, exp_sum=400, sign=1 -> 0xFF800000, overflow=1.
  - exp_sum=100, sign=0 -> 0x00000000, underflow=1.
  - prod=0, sign=1 -> 0x80000000, no flags.
- Backpressure: hold out_ready=0 for 5 cycles with in_valid=1 -> result stable, in_ready=0, no second capture. Raise out_ready -> one transfer, then in_ready=1.
- Reset mid-operation: drive rst=0 during NORM -> out_valid never asserts. The next input after reset produces a correct result (1.0×1.0: prod=0x400000000000, exp_sum=254 -> 0x3F800000).
